// File: rtl/libstf.sv
// libstf: shared stream types, request descriptor and splitter defaults
package libstf;
  typedef logic [47:0] vaddress_t;
  typedef logic [31:0] alloc_size_t;
  localparam int DEFAULT_MAX_TRANSFER = 2048;
  localparam int DEFAULT_PAGE_SIZE = 4096;
  typedef struct packed {
    vaddress_t vaddr;
    logic [$clog2(DEFAULT_MAX_TRANSFER):0] len;
    logic last;
  } mem_req_t;
endpackage

// File: rtl/mem_chunk_calc.sv
// mem_chunk_calc: length of the next request bounded by remaining bytes, max transfer and page end
module mem_chunk_calc import libstf::*; #(
  parameter int MAX_TRANSFER = DEFAULT_MAX_TRANSFER,
  parameter int PAGE_SIZE = DEFAULT_PAGE_SIZE
) (
  input  logic [$clog2(PAGE_SIZE)-1:0]  i_off,
  input  alloc_size_t                   i_rem,
  output logic [$clog2(MAX_TRANSFER):0] o_len,
  output logic                          o_last
);
  localparam int PW = $clog2(PAGE_SIZE);
  localparam int LW = $clog2(MAX_TRANSFER) + 1;
  typedef logic [PW:0] page_t;
  typedef logic [LW-1:0] len_t;
  page_t w_page;
  len_t  w_lim;
  assign w_page = page_t'(PAGE_SIZE) - {1'b0, i_off};
  assign w_lim  = (w_page < page_t'(MAX_TRANSFER)) ? w_page[LW-1:0] : len_t'(MAX_TRANSFER);
  assign o_last = i_rem <= alloc_size_t'(w_lim);
  assign o_len  = o_last ? i_rem[LW-1:0] : w_lim;
endmodule

// File: rtl/mem_buffer_splitter.sv
// mem_buffer_splitter: splits buffer descriptors into bounded, page-safe memory requests; MEM_SPLIT_STATS_EN adds statistics counters
module mem_buffer_splitter import libstf::*; #(
  parameter int MAX_TRANSFER = DEFAULT_MAX_TRANSFER,
  parameter int PAGE_SIZE = DEFAULT_PAGE_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  vaddress_t                     in_vaddr,
  input  alloc_size_t                   in_size,
  output logic                          out_valid,
  input  logic                          out_ready,
  output vaddress_t                     out_vaddr,
  output logic [$clog2(MAX_TRANSFER):0] out_len,
  output logic                          out_last
`ifdef MEM_SPLIT_STATS_EN
  ,
  output logic [31:0]                   stat_buffers,
  output logic [31:0]                   stat_requests,
  output logic [31:0]                   stat_zero
`endif
);
  localparam int PW = $clog2(PAGE_SIZE);
  localparam int LW = $clog2(MAX_TRANSFER) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  logic [0:0]  r_state;
  vaddress_t   r_addr, r_vaddr, w_next_addr;
  alloc_size_t r_rem, w_next_rem;
  logic [LW-1:0] r_len, w_len;
  logic r_last, w_last, w_idle, w_accept, w_start, w_adv;
  assign w_idle      = r_state == IDLE;
  assign w_accept    = w_idle && in_valid;
  assign w_start     = w_accept && in_size != '0;
  assign w_adv       = !w_idle && out_ready;
  assign w_next_addr = r_addr + vaddress_t'(r_len);
  assign w_next_rem  = r_rem - alloc_size_t'(r_len);
  assign in_ready    = w_idle;
  assign out_valid   = !w_idle;
  assign out_vaddr   = r_vaddr;
  assign out_len     = r_len;
  assign out_last    = r_last;
  mem_chunk_calc #(.MAX_TRANSFER(MAX_TRANSFER), .PAGE_SIZE(PAGE_SIZE)) u_calc (
    .i_off (w_idle ? in_vaddr[PW-1:0] : w_next_addr[PW-1:0]),
    .i_rem (w_idle ? in_size : w_next_rem),
    .o_len (w_len),
    .o_last(w_last)
  );
  // walk the buffer: latch on accept, advance on each handshake, preload the next chunk
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_vaddr <= '0;
      r_len   <= '0;
      r_last  <= 1'b0;
    end else begin
      if (w_start) begin
        r_state <= ISSUE;
        r_addr  <= in_vaddr;
        r_rem   <= in_size;
      end
      if (w_adv) begin
        r_addr  <= w_next_addr;
        r_rem   <= w_next_rem;
        r_state <= r_last ? IDLE : ISSUE;
      end
      if (w_start || (w_adv && !r_last)) begin
        r_vaddr <= w_idle ? in_vaddr : w_next_addr;
        r_len   <= w_len;
        r_last  <= w_last;
      end
    end
  end
`ifdef MEM_SPLIT_STATS_EN
  // count accepted descriptors, output handshakes and dropped zero-size descriptors
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_buffers  <= '0;
      stat_requests <= '0;
      stat_zero     <= '0;
    end else begin
      stat_buffers  <= stat_buffers + 32'(w_accept);
      stat_requests <= stat_requests + 32'(w_adv);
      stat_zero     <= stat_zero + 32'(w_accept && in_size == '0);
    end
  end
`endif
endmodule

// File: tb/tb_mem_buffer_splitter.sv
// tb_mem_buffer_splitter: randomized and directed checks against a queue-based request model
module tb_mem_buffer_splitter;
  localparam int MT = 2048;
  localparam int PS = 4096;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
  logic [47:0] in_vaddr = '0, out_vaddr;
  logic [31:0] in_size = '0;
  logic [11:0] out_len;
`ifdef MEM_SPLIT_STATS_EN
  logic [31:0] stat_buffers, stat_requests, stat_zero;
`endif
  mem_buffer_splitter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vaddr(in_vaddr), .in_size(in_size), .out_valid(out_valid),
    .out_ready(out_ready), .out_vaddr(out_vaddr), .out_len(out_len), .out_last(out_last)
`ifdef MEM_SPLIT_STATS_EN
    , .stat_buffers(stat_buffers), .stat_requests(stat_requests), .stat_zero(stat_zero)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [47:0] a;
    int l;
    bit last;
  } req_t;
  req_t q[$];
  req_t tmp[$];
  int n_tests = 0, n_fail = 0;
  int m_buf = 0, m_req = 0, m_zero = 0;
  bit chk_en = 1'b0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // expected request list of one descriptor, straight from the chunking rule
  function automatic void split(input logic [47:0] a, input logic [31:0] s);
    longint r = longint'(s);
    logic [47:0] x = a;
    tmp.delete();
    while (r > 0) begin
      longint pg = longint'(PS) - longint'(x % 48'(PS));
      longint l = r;
      if (l > MT) l = MT;
      if (l > pg) l = pg;
      tmp.push_back('{x, int'(l), l == r});
      x = x + 48'(l);
      r = r - l;
    end
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // compare DUT against the model each cycle, then apply the upcoming edge's handshakes to the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(q.size() == 0));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0 && out_valid) begin
        check("out_vaddr", 64'(out_vaddr), 64'(q[0].a));
        check("out_len", 64'(out_len), 64'(q[0].l));
        check("out_last", 64'(out_last), 64'(q[0].last));
      end
`ifdef MEM_SPLIT_STATS_EN
      check("stat_buffers", 64'(stat_buffers), 64'(m_buf));
      check("stat_requests", 64'(stat_requests), 64'(m_req));
      check("stat_zero", 64'(stat_zero), 64'(m_zero));
`endif
      if (rst) begin
        q.delete();
        m_buf = 0;
        m_req = 0;
        m_zero = 0;
      end else if (q.size() == 0) begin
        if (in_valid) begin
          m_buf++;
          if (in_size == 0) m_zero++;
          else begin
            split(in_vaddr, in_size);
            foreach (tmp[i]) q.push_back(tmp[i]);
          end
        end
      end else if (out_ready) begin
        void'(q.pop_front());
        m_req++;
      end
    end
  end
  task automatic expect_req(input string name, input logic [47:0] a, input int l, input bit last);
    check({name, "_vaddr"}, 64'(out_vaddr), 64'(a));
    check({name, "_len"}, 64'(out_len), 64'(l));
    check({name, "_last"}, 64'(out_last), 64'(last));
  endtask
  initial begin
    split(48'h0F00, 32'h300);
    check("model_pc_n", 64'(tmp.size()), 64'd2);
    check("model_pc_len0", 64'(tmp[0].l), 64'h100);
    check("model_pc_addr1", 64'(tmp[1].a), 64'h1000);
    split(48'hFFFF_FFFF_FFF0, 32'h20);
    check("model_wrap_addr1", 64'(tmp[1].a), 64'h0);
    check("model_wrap_last1", 64'(tmp[1].last), 64'd1);
    tick;
    chk_en = 1'b1;
    check("rst_vaddr", 64'(out_vaddr), 64'h0);
    check("rst_len", 64'(out_len), 64'h0);
    check("rst_last", 64'(out_last), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    tick;
    rst = 1'b0;
    // aligned split
    out_ready = 1'b1; in_valid = 1'b1; in_vaddr = 48'h1000; in_size = 32'h1800;
    tick;
    in_valid = 1'b0;
    expect_req("al0", 48'h1000, 2048, 1'b0); tick;
    expect_req("al1", 48'h1800, 2048, 1'b0); tick;
    expect_req("al2", 48'h2000, 2048, 1'b1); tick;
    check("al_ready", 64'(in_ready), 64'h1);
    // page crossing
    in_valid = 1'b1; in_vaddr = 48'h0F00; in_size = 32'h300;
    tick;
    in_valid = 1'b0;
    expect_req("pc0", 48'h0F00, 'h100, 1'b0); tick;
    expect_req("pc1", 48'h1000, 'h200, 1'b1); tick;
    // zero size
    in_valid = 1'b1; in_vaddr = 48'h5000; in_size = 32'h0;
    tick;
    in_valid = 1'b0;
    check("zero_ready", 64'(in_ready), 64'h1);
    check("zero_valid", 64'(out_valid), 64'h0);
`ifdef MEM_SPLIT_STATS_EN
    check("zero_stat_zero", 64'(stat_zero), 64'd1);
    check("zero_stat_buffers", 64'(stat_buffers), 64'd3);
`endif
    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_vaddr = 48'h2000; in_size = 32'h1000;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_req("bp_hold", 48'h2000, 2048, 1'b0);
      tick;
    end
    out_ready = 1'b1;
    tick;
    expect_req("bp_next", 48'h2800, 2048, 1'b1);
    tick;
    // reset during second request
    in_valid = 1'b1; in_vaddr = 48'h1000; in_size = 32'h1800;
    tick;
    in_valid = 1'b0;
    tick;
    expect_req("rm_second", 48'h1800, 2048, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rm_valid", 64'(out_valid), 64'h0);
    check("rm_ready", 64'(in_ready), 64'h1);
`ifdef MEM_SPLIT_STATS_EN
    check("rm_stat_requests", 64'(stat_requests), 64'd0);
`endif
    in_valid = 1'b1; in_vaddr = 48'h3000; in_size = 32'd16;
    tick;
    in_valid = 1'b0;
    expect_req("rm_new", 48'h3000, 16, 1'b1);
    tick;
    // back-to-back descriptors
    in_valid = 1'b1; in_vaddr = 48'h4000; in_size = 32'd2048;
    tick;
    in_vaddr = 48'h8000;
    expect_req("bb0", 48'h4000, 2048, 1'b1);
    tick;
    check("bb_bubble_valid", 64'(out_valid), 64'h0);
    check("bb_bubble_ready", 64'(in_ready), 64'h1);
    tick;
    in_valid = 1'b0;
    expect_req("bb1", 48'h8000, 2048, 1'b1);
    tick;
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int k = int'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      case (k)
        0: in_vaddr = 48'({$urandom(), $urandom()});
        1: in_vaddr = 48'({$urandom(), $urandom()}) & ~48'hFFF | 48'(PS - int'($urandom_range(1, 64)));
        2: in_vaddr = 48'hFFFF_FFFF_E000 + 48'($urandom_range(0, 'h1FFF));
        default: in_vaddr = 48'($urandom_range(0, 'h3FFF));
      endcase
      case ($urandom_range(0, 7))
        0: in_size = 32'd0;
        1, 2, 3: in_size = $urandom_range(1, 64);
        default: in_size = $urandom_range(1, 9000);
      endcase
      tick;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 200 && !in_ready; i++) tick;
    check("drain_ready", 64'(in_ready), 64'h1);
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_buffer_splitter.md
# mem_buffer_splitter

Downstream consumer of the per-stream buffer descriptors produced by the memory-configuration stage. It takes one buffer descriptor per handshake (virtual address plus allocation size) and emits a sequence of memory transfer requests. Each request is no longer than `MAX_TRANSFER` bytes and never crosses a `PAGE_SIZE` boundary. It sits between the config-driven `buffer` ready/valid and the stream's DMA/host-memory request port; one instance per stream.

## Interface
Parameters:
- `MAX_TRANSFER`, default 2048: maximum bytes per request; power of two, ≤ `PAGE_SIZE`.
- `PAGE_SIZE`, default 4096: boundary no request may cross; power of two.

Ports:
- `clk`, in, 1: single clock; all logic synchronous to rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: buffer descriptor valid.
- `in_ready`, out, 1: splitter accepts a descriptor.
- `in_vaddr`, in, 48 (`vaddress_t`): buffer start byte address.
- `in_size`, in, 32 (`alloc_size_t`): buffer size in bytes.
- `out_valid`, out, 1: request valid.
- `out_ready`, in, 1: downstream accepts the request.
- `out_vaddr`, out, 48: request start address.
- `out_len`, out, `$clog2(MAX_TRANSFER)+1`: request length in bytes, 1..`MAX_TRANSFER`.
- `out_last`, out, 1: final request of the current buffer.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - ISSUE: `in_ready`=0, `out_valid`=1.
- IDLE, `in_valid`&&`in_size`≠0:
  - Latch `cur_addr`=`in_vaddr`, `rem`=`in_size`.
  - Load the first request into the output registers.
  - Go to ISSUE.
- IDLE, `in_valid`&&`in_size`=0: descriptor is consumed and dropped; no request; stay in IDLE.
- Chunk length: `len = min(rem, MAX_TRANSFER, PAGE_SIZE - cur_addr[log2(PAGE_SIZE)-1:0])`.
  - `last = (len == rem)`.
  - Arithmetic is unsigned. `rem` is 32 bits. Address add is 48-bit and wraps modulo 2^48; no error is raised.
- ISSUE, `out_ready` high:
  - `cur_addr += len`, `rem -= len`.
  - If `out_last`, go to IDLE. Otherwise load the next chunk into the output registers and stay in ISSUE.
- `out_vaddr`, `out_len` and `out_last` are registered and hold stable while `out_valid`&&!`out_ready`.
- Reset mid-operation: the in-flight buffer is abandoned with no further requests; FSM returns to IDLE.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `out_vaddr`=0, `out_len`=0, `out_last`=0.
  - `cur_addr`=0, `rem`=0, all statistics counters=0.
- Descriptor accepted at edge t → first request `out_valid` at t+1.
- Sustained throughput is one request per cycle while `out_ready`=1.
- Last request accepted at edge t → `in_ready`=1 from t+1. The next descriptor can be accepted at edge t+1, with its first request at t+2. The one-cycle bubble per buffer is required.
- Zero-size descriptor accepted at t → `in_ready` remains 1 at t+1.
- `in_ready` does not depend combinationally on `out_ready`.
- `out_valid` is never withdrawn before a handshake.

## Configuration
- Macro `MEM_SPLIT_STATS_EN`.
- Defined: adds outputs `stat_buffers` (32-bit), `stat_requests` (32-bit) and `stat_zero` (32-bit).
  - `stat_buffers` counts accepted descriptors, including zero-size.
  - `stat_requests` counts output handshakes.
  - `stat_zero` counts dropped zero-size descriptors.
  - All three wrap at 2^32 and are cleared by `rst`.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- In the shared `libstf` package:
  - `vaddress_t` and `alloc_size_t`, already present.
  - New `mem_req_t` packed struct `{vaddr, len, last}`.
  - New `DEFAULT_MAX_TRANSFER` = 2048 and `DEFAULT_PAGE_SIZE` = 4096.
- One sub-module, `mem_chunk_calc`: combinational len/last computation from `cur_addr`, `rem` and the parameters. It is reused for the first chunk (from the inputs) and for subsequent chunks (from the registers).

## Test plan
- Aligned split: vaddr 0x1000, size 0x1800, `out_ready`=1 → requests (0x1000, 2048, 0), (0x1800, 2048, 0), (0x2000, 2048, 1) on consecutive cycles starting one cycle after accept; `in_ready`=1 the cycle after the last.
- Page crossing: vaddr 0x0F00, size 0x300 → (0x0F00, 0x100, 0), (0x1000, 0x200, 1).
- Zero size: vaddr 0x5000, size 0 → no `out_valid`; `in_ready` stays 1; with `MEM_SPLIT_STATS_EN`, `stat_zero`=1 and `stat_buffers`=1.
- Backpressure: vaddr 0x2000, size 0x1000, `out_ready` low for 5 cycles after `out_valid` → `out_vaddr`=0x2000, `out_len`=2048, `out_last`=0 held stable all 5 cycles; completion then proceeds normally.
- Reset mid-operation: assert `rst` during the second request of a 3-request buffer → next cycle `out_valid`=0, `in_ready`=1, counters 0; a new descriptor vaddr 0x3000, size 16 yields (0x3000, 16, 1).
- Back-to-back buffers: two descriptors of size 2048 presented continuously → each yields one last request; exactly one idle bubble cycle between them; `stat_requests`=2.
